// File: rtl/mmcm_drp_reconfig_ctrl_if.sv
// DRP bus between the reconfiguration sequencer (master) and the MMCM DRP port (slave).
interface mmcm_drp_reconfig_ctrl_if;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_daddr, drp_den, drp_dwe, drp_di,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_daddr, drp_den, drp_dwe, drp_di,
        output drp_do, drp_drdy
    );
endinterface

// File: rtl/mmcm_drp_reconfig_ctrl.sv
// Runtime MMCM retune: holds the MMCM in reset, read-modify-writes the CLKFBOUT/CLKOUT1 divider
// registers over DRP, releases reset and waits for lock, reporting done or an error code.
module mmcm_drp_reconfig_ctrl #(
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned DRDY_TIMEOUT = 255,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [6:0]  cfg_mult,
    input  logic [6:0]  cfg_div,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    mmcm_drp_reconfig_ctrl_if.master drp
);

    typedef enum logic [3:0] {
        StIdle, StHoldPre, StRd, StRdWait, StWr, StWrWait, StHoldPost, StWaitLock, StAbort
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [6:0]  mult_q, mult_d, div_q, div_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d, mmcm_rst_q, mmcm_rst_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [1:0]  lock_sync_q;
    logic        cfg_legal;
    logic [6:0]  op_val;

    function automatic logic [6:0] op_addr(input logic [1:0] op);
        unique case (op)
            2'd0:    op_addr = 7'h14;
            2'd1:    op_addr = 7'h15;
            2'd2:    op_addr = 7'h0A;
            default: op_addr = 7'h0B;
        endcase
    endfunction

    // Even ops target reg1 (high/low counts), odd ops reg2 (edge/nocount); a low count of 64
    // wraps to 0 in the 6-bit field, which is how the MMCM encodes it.
    function automatic logic [15:0] merge_word(input logic [1:0] op, input logic [6:0] v,
                                               input logic [15:0] rd);
        logic [5:0] high;
        logic [6:0] low;
        high = v[6:1];
        low  = v - {1'b0, high};
        if (!op[0]) merge_word = {rd[15:12], high, low[5:0]};
        else        merge_word = {rd[15:8], v[0], (v == 7'd1), rd[5:0]};
    endfunction

    assign cfg_legal = (cfg_mult >= 7'd5) && (cfg_mult <= 7'd64) && (cfg_div != 7'd0);
    assign op_val    = op_q[1] ? div_q : mult_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        mult_d     = mult_q;
        div_d      = div_q;
        daddr_d    = daddr_q;
        di_d       = di_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        mmcm_rst_d = mmcm_rst_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mult_d = cfg_mult;
                    div_d  = cfg_div;
                    if (!cfg_legal) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end else begin
                        busy_d     = 1'b1;
                        mmcm_rst_d = 1'b1;
                        err_code_d = 2'd0;
                        cnt_d      = '0;
                        state_d    = StHoldPre;
                    end
                end
            end
            StHoldPre: begin
                if (32'(cnt_q) == RST_HOLD - 1) begin
                    cnt_d   = '0;
                    op_d    = 2'd0;
                    daddr_d = op_addr(2'd0);
                    state_d = StRd;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRd: begin
                cnt_d   = '0;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (drp.drp_drdy) begin
                    di_d    = merge_word(op_q, op_val, drp.drp_do);
                    state_d = StWr;
                end else if (32'(cnt_q) == DRDY_TIMEOUT - 1) begin
                    err_code_d = 2'd2;
                    state_d    = StAbort;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWr: begin
                cnt_d   = '0;
                state_d = StWrWait;
            end
            StWrWait: begin
                if (drp.drp_drdy) begin
                    cnt_d = '0;
                    if (op_q == 2'd3) begin
                        state_d = StHoldPost;
                    end else begin
                        op_d    = op_q + 2'd1;
                        daddr_d = op_addr(op_q + 2'd1);
                        state_d = StRd;
                    end
                end else if (32'(cnt_q) == DRDY_TIMEOUT - 1) begin
                    err_code_d = 2'd2;
                    state_d    = StAbort;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StHoldPost: begin
                if (32'(cnt_q) == RST_HOLD - 1) begin
                    cnt_d      = '0;
                    mmcm_rst_d = 1'b0;
                    state_d    = StWaitLock;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitLock: begin
                if (lock_sync_q[1]) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (32'(cnt_q) == LOCK_TIMEOUT - 1) begin
                    err_code_d = 2'd3;
                    state_d    = StAbort;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StAbort: begin
                mmcm_rst_d = 1'b0;
                err_d      = 1'b1;
                busy_d     = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= '0;
            mult_q      <= '0;
            div_q       <= '0;
            daddr_q     <= '0;
            di_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            mmcm_rst_q  <= 1'b0;
            lock_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            mult_q      <= mult_d;
            div_q       <= div_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            mmcm_rst_q  <= mmcm_rst_d;
            lock_sync_q <= {lock_sync_q[0], mmcm_locked};
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign mmcm_rst      = mmcm_rst_q;
    assign drp.drp_den   = (state_q == StRd) || (state_q == StWr);
    assign drp.drp_dwe   = (state_q == StWr);
    assign drp.drp_daddr = daddr_q;
    assign drp.drp_di    = di_q;

endmodule
